uart_cmd_rx: RTL and testbench
==============================

// Module: uart_cmd_rx
// PURPOSE
//  UART command front-end for the life core. Receives framed 8N1 serial commands on the board
//  UART line and presents them on the core's cmd / cmd_arg0 / cmd_valid / cmd_ready interface.
//  Sits directly upstream of the life core as an alternative source to the push-button command generator.
//  Frame: 1 header byte + 4 argument bytes (arg0, little-endian).
// PARAMETERS
//  CLKS_PER_BIT   434        clk cycles per UART bit (50 MHz / 115200); must be >= 4
//  TIMEOUT_CLKS   4_000_000  max clk cycles between argument bytes before the frame is abandoned
//  HDR_TAG        5'b10100   required header bits [7:3]; header byte = {HDR_TAG, cmd[2:0]}
// PORTS
//  clk         in   1   system clock, same domain as the life core
//  reset       in   1   asynchronous, active-low (0 = reset asserted)
//  rx          in   1   UART serial input, idle high, asynchronous to clk
//  cmd         out  3   command opcode to core
//  cmd_arg0    out  32  command argument to core
//  cmd_valid   out  1   command available; held until accepted
//  cmd_ready   in   1   core accepts command when high with cmd_valid
//  frame_err   out  1   1-cycle pulse: bad stop bit, false start in frame, or inter-byte timeout
//  overrun     out  1   1-cycle pulse: byte completed while a command was pending and dropped
// BEHAVIOUR
//  Reset values: cmd=0, cmd_arg0=0, cmd_valid=0, frame_err=0, overrun=0; parser IDLE; receiver idle.
//  Reset is async assert, takes effect mid-byte or mid-frame; partial frame discarded, no pulses.
//  rx passes a 2-FF synchroniser (flops reset to 1) before any use.
//  Byte receiver:
//   - idle: wait for synchronised rx = 0; count CLKS_PER_BIT/2 (integer div) to mid start bit.
//   - mid start: rx = 1 -> false start, return idle silently, no byte.
//   - 8 data bits sampled every CLKS_PER_BIT at mid-bit, LSB first.
//   - stop bit sampled at mid-bit: 1 -> byte_done pulse with data; 0 -> frame_err pulse, byte dropped,
//     parser forced to IDLE; receiver waits for rx = 1 before next start search.
//   - receiver never stalls; it runs regardless of parser state.
//  Parser FSM (advances only on byte_done):
//   - IDLE: byte[7:3]==HDR_TAG -> latch cmd=byte[2:0], go ARG0; else ignore byte, no error.
//   - ARG0..ARG3: store byte into cmd_arg0[8n+7:8n]; ARG3 -> HOLD.
//   - HOLD: cmd_valid=1; cmd and cmd_arg0 stable. cmd_valid & cmd_ready at a clk edge ->
//     cmd_valid=0 next cycle, state IDLE.
//   - Latency: cmd_valid rises 1 clk after byte_done of the 4th argument byte.
//  Timeout: in ARG0..ARG3, counter reset on every byte_done; reaching TIMEOUT_CLKS -> frame_err pulse,
//   state IDLE. Counter idle (0) in IDLE and HOLD. No timeout in HOLD (core may stall indefinitely).
//  Overrun: byte_done in HOLD without handshake that cycle -> byte dropped, overrun pulse.
//  Simultaneous handshake and byte_done in HOLD: handshake wins, the byte is evaluated as if in
//   IDLE (valid header -> ARG0 next cycle); no overrun.
//  Simultaneous timeout and byte_done: byte_done wins (byte stored, counter cleared).
//  cmd_arg0 holds the last frame's value outside HOLD; bytes written in place as they arrive.
//  Width rules: bit counter 3 b; baud counter $clog2(CLKS_PER_BIT) b; timeout counter
//   $clog2(TIMEOUT_CLKS+1) b; all saturate/clear explicitly, never wrap.
// STRUCTURE
//  Shared package (life_pkg): CMD_W=3 command width, ARG_W=32, HDR_TAG default, parser state enum.
//  One sub-module: uart_rx_byte (synchroniser + bit timing + stop check; outputs byte_done, data, stop_err).
//  Parser, timeout counter and output register live in uart_cmd_rx.
// TESTING (CLKS_PER_BIT=8, TIMEOUT_CLKS=400, cmd_ready tied 1 unless noted)
//  1 Send A3 78 56 34 12 -> single cmd_valid cycle, cmd=3, cmd_arg0=32'h12345678, no error pulses.
//  2 cmd_ready=0, send A1 EF BE AD DE then 55 -> cmd_valid held, cmd=1, arg0=DEADBEEF stable,
//    one overrun pulse on 55; raise cmd_ready -> valid drops next cycle.
//  3 Send 42, then A5 01 00 00 00 -> 42 ignored silently; cmd=5, cmd_arg0=1.
//  4 Send A2 11, idle 400+ clks, then A4 00 00 00 80 -> one frame_err; cmd=4, arg0=32'h80000000 only.
//  5 Send A6 with stop bit 0, then A7 01 02 03 04 -> frame_err pulse, no command from A6;
//    cmd=7, arg0=32'h04030201. Also 2-clk rx low glitch -> no byte, no pulse.
//  6 Assert reset during 3rd argument byte, release, send A0 FF FF FF FF -> outputs 0 during reset;
//    afterwards cmd=0, arg0=32'hFFFFFFFF, no stale-frame command.

Source files
------------

// File: rtl/life_pkg.sv
// Shared definitions for the life core command path: widths, header tag and
// the UART command parser state encoding.
package life_pkg;

  localparam int CMD_W = 3;
  localparam int ARG_W = 32;
  localparam logic [4:0] HDR_TAG_DEFAULT = 5'b10100;

  typedef enum logic [2:0] {
    P_IDLE,
    P_ARG0,
    P_ARG1,
    P_ARG2,
    P_ARG3,
    P_HOLD
  } parser_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  function automatic logic is_header(input logic [7:0] b, input logic [4:0] tag);
    return b[7:3] == tag;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rx synchroniser, mid-bit sampling and stop-bit check.
// Free-running; it never waits on whoever consumes its bytes.
module uart_rx_byte
  import life_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_done,
  output logic [7:0] data,
  output logic       stop_err
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic              rx_meta;
  logic              rx_sync;
  rx_state_t         state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;

  // Synchroniser flops reset to the idle line level so reset release never
  // looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments on every flop so each one samples the
      // pre-edge value; blocking here would collapse the two stages into one.
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RX_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      data      <= '0;
      byte_done <= 1'b0;
      stop_err  <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      stop_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          baud_cnt <= '0;
          if (!rx_sync) state <= RX_START;
        end

        RX_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            // Line back high at mid start bit: glitch, drop it silently.
            state    <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        RX_DATA: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt <= '0;
            shift    <= {rx_sync, shift[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        RX_STOP: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt <= '0;
            if (rx_sync) begin
              byte_done <= 1'b1;
              data      <= shift;
              state     <= RX_IDLE;
            end else begin
              stop_err <= 1'b1;
              state    <= RX_WAIT_HIGH;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // A low stop bit may be a break or a misaligned stream; resync only
        // once the line has returned to idle.
        RX_WAIT_HIGH: begin
          baud_cnt <= '0;
          if (rx_sync) state <= RX_IDLE;
        end

        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command front-end for the life core: turns framed serial commands
// (header + 4 little-endian argument bytes) into a cmd/cmd_valid/cmd_ready transfer.
module uart_cmd_rx
  import life_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         TIMEOUT_CLKS = 4_000_000,
  parameter logic [4:0] HDR_TAG      = HDR_TAG_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  output logic [CMD_W-1:0] cmd,
  output logic [ARG_W-1:0] cmd_arg0,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CLKS);

  logic          byte_done;
  logic [7:0]    rx_data;
  logic          stop_err;

  parser_state_t state;
  parser_state_t arg_next;
  logic [1:0]    arg_lane;
  logic [TO_W-1:0] to_cnt;
  logic          hdr_ok;
  logic          handshake;
  logic          timeout_hit;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .byte_done(byte_done),
    .data     (rx_data),
    .stop_err (stop_err)
  );

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case
    // leaves a variable unassigned and infers a latch.
    arg_lane    = 2'd0;
    arg_next    = P_IDLE;
    timeout_hit = 1'b0;
    hdr_ok      = byte_done && is_header(rx_data, HDR_TAG);
    handshake   = cmd_valid && cmd_ready;
    case (state)
      P_ARG0: begin arg_lane = 2'd0; arg_next = P_ARG1; end
      P_ARG1: begin arg_lane = 2'd1; arg_next = P_ARG2; end
      P_ARG2: begin arg_lane = 2'd2; arg_next = P_ARG3; end
      P_ARG3: begin arg_lane = 2'd3; arg_next = P_HOLD; end
      default: ;
    endcase
    if (state inside {P_ARG0, P_ARG1, P_ARG2, P_ARG3}) begin
      timeout_hit = !byte_done && (to_cnt == TO_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= P_IDLE;
      cmd       <= '0;
      cmd_arg0  <= '0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      to_cnt    <= '0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        P_IDLE: begin
          to_cnt <= '0;
          if (stop_err) frame_err <= 1'b1;
          if (hdr_ok) begin
            cmd   <= rx_data[CMD_W-1:0];
            state <= P_ARG0;
          end
        end

        P_ARG0, P_ARG1, P_ARG2, P_ARG3: begin
          if (stop_err || timeout_hit) begin
            frame_err <= 1'b1;
            to_cnt    <= '0;
            state     <= P_IDLE;
          end else if (byte_done) begin
            cmd_arg0[8*arg_lane +: 8] <= rx_data;
            to_cnt <= '0;
            state  <= arg_next;
            if (arg_next == P_HOLD) cmd_valid <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        // A bad stop bit while holding is still reported, but the pending
        // command survives: cmd_valid is only withdrawn by the core.
        P_HOLD: begin
          to_cnt <= '0;
          if (stop_err) frame_err <= 1'b1;
          if (handshake) begin
            cmd_valid <= 1'b0;
            if (hdr_ok) begin
              cmd   <= rx_data[CMD_W-1:0];
              state <= P_ARG0;
            end else begin
              state <= P_IDLE;
            end
          end else if (byte_done) begin
            overrun <= 1'b1;
          end
        end

        default: begin
          state     <= P_IDLE;
          cmd_valid <= 1'b0;
          to_cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: serial stimulus with directed and random frames,
// expected commands and pulse counts derived from the frame format.
module tb_uart_cmd_rx;

  localparam int         CPB = 8;
  localparam int         TO  = 400;
  localparam logic [4:0] HDR = 5'b10100;

  typedef struct packed {
    logic [2:0]  c;
    logic [31:0] a;
  } cmd_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic        cmd_ready = 1'b1;
  logic [2:0]  cmd;
  logic [31:0] cmd_arg0;
  logic        cmd_valid;
  logic        frame_err;
  logic        overrun;

  cmd_t got_q[$];
  cmd_t exp_q[$];
  int   n_ferr = 0;
  int   n_ovr = 0;
  int   n_vcyc = 0;
  int   checks = 0;
  int   errors = 0;

  uart_cmd_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .cmd      (cmd),
    .cmd_arg0 (cmd_arg0),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      if (cmd_valid && cmd_ready) got_q.push_back({cmd, cmd_arg0});
      if (cmd_valid) n_vcyc++;
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
    tick(2 * CPB);
  endtask

  task automatic send_frame(input logic [2:0] c, input logic [31:0] a);
    send_byte({HDR, c}, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick(3);
    checks++;
    if ({cmd, cmd_arg0, cmd_valid, frame_err, overrun} !== 38'd0) begin
      errors++;
      $display("FAIL reset_outputs got cmd=%0h arg=%h v=%b fe=%b ov=%b want all 0",
               cmd, cmd_arg0, cmd_valid, frame_err, overrun);
    end
    reset = 1'b1;
    tick(5);
  endtask

  task automatic test_single;
    int f0 = n_ferr, o0 = n_ovr, v0 = n_vcyc;
    got_q.delete();
    send_frame(3'd3, 32'h1234_5678);
    tick(10);
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL single_count got %0d want 1", got_q.size());
    end else if (got_q[0] !== {3'd3, 32'h1234_5678}) begin
      errors++;
      $display("FAIL single_cmd got %h want %h", got_q[0], {3'd3, 32'h1234_5678});
    end
    checks++;
    if (n_vcyc - v0 != 1) begin
      errors++;
      $display("FAIL single_valid_cycles got %0d want 1", n_vcyc - v0);
    end
    checks++;
    if (n_ferr != f0 || n_ovr != o0) begin
      errors++;
      $display("FAIL single_pulses got fe=%0d ov=%0d want 0 0", n_ferr - f0, n_ovr - o0);
    end
  endtask

  task automatic test_backpressure;
    int o0 = n_ovr;
    got_q.delete();
    cmd_ready = 1'b0;
    send_frame(3'd1, 32'hDEAD_BEEF);
    tick(20);
    checks++;
    if (cmd_valid !== 1'b1 || cmd !== 3'd1 || cmd_arg0 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL hold_outputs got v=%b cmd=%0h arg=%h want 1 1 deadbeef", cmd_valid, cmd, cmd_arg0);
    end
    send_byte(8'h55, 1'b1);
    tick(5);
    checks++;
    if (n_ovr - o0 != 1) begin
      errors++;
      $display("FAIL overrun_count got %0d want 1", n_ovr - o0);
    end
    checks++;
    if (cmd_valid !== 1'b1 || cmd_arg0 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL hold_after_overrun got v=%b arg=%h want 1 deadbeef", cmd_valid, cmd_arg0);
    end
    cmd_ready = 1'b1;
    tick(1);
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_drop got %b want 0", cmd_valid);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {3'd1, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL backpressure_cmd got count %0d want 1 of 1/deadbeef", got_q.size());
    end
  endtask

  task automatic test_bad_header;
    int f0 = n_ferr;
    got_q.delete();
    send_byte(8'h42, 1'b1);
    tick(10);
    checks++;
    if (got_q.size() != 0 || n_ferr != f0) begin
      errors++;
      $display("FAIL ignore_42 got cmds=%0d fe=%0d want 0 0", got_q.size(), n_ferr - f0);
    end
    send_frame(3'd5, 32'h0000_0001);
    tick(10);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {3'd5, 32'h1}) begin
      errors++;
      $display("FAIL after_ignore_cmd got count %0d cmd=%0h arg=%h want 5/00000001",
               got_q.size(), cmd, cmd_arg0);
    end
  endtask

  task automatic test_timeout;
    int f0 = n_ferr;
    got_q.delete();
    send_byte(8'hA2, 1'b1);
    send_byte(8'h11, 1'b1);
    tick(TO + 50);
    checks++;
    if (n_ferr - f0 != 1) begin
      errors++;
      $display("FAIL timeout_pulse got %0d want 1", n_ferr - f0);
    end
    send_frame(3'd4, 32'h8000_0000);
    tick(10);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {3'd4, 32'h8000_0000} || n_ferr - f0 != 1) begin
      errors++;
      $display("FAIL timeout_recovery got count %0d arg=%h fe=%0d want 1 80000000 1",
               got_q.size(), cmd_arg0, n_ferr - f0);
    end
  endtask

  task automatic test_stop_err;
    int f0 = n_ferr;
    got_q.delete();
    send_byte(8'hA6, 1'b0);
    tick(5);
    checks++;
    if (n_ferr - f0 != 1) begin
      errors++;
      $display("FAIL stop_err_pulse got %0d want 1", n_ferr - f0);
    end
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(5 * CPB);
    checks++;
    if (n_ferr - f0 != 1 || got_q.size() != 0) begin
      errors++;
      $display("FAIL glitch got fe=%0d cmds=%0d want 1 0", n_ferr - f0, got_q.size());
    end
    send_frame(3'd7, 32'h0403_0201);
    tick(10);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {3'd7, 32'h0403_0201}) begin
      errors++;
      $display("FAIL stop_err_recovery got count %0d cmd=%0h arg=%h want 7/04030201",
               got_q.size(), cmd, cmd_arg0);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] third = 8'h33;
    int f0, o0;
    send_byte(8'hA3, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = third[i];
      tick(CPB);
    end
    reset = 1'b0;
    rx = 1'b1;
    tick(4);
    checks++;
    if ({cmd, cmd_arg0, cmd_valid, frame_err, overrun} !== 38'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got cmd=%0h arg=%h v=%b want all 0", cmd, cmd_arg0, cmd_valid);
    end
    reset = 1'b1;
    tick(3 * CPB);
    f0 = n_ferr;
    o0 = n_ovr;
    got_q.delete();
    send_frame(3'd0, 32'hFFFF_FFFF);
    tick(10);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {3'd0, 32'hFFFF_FFFF} || n_ferr != f0 || n_ovr != o0) begin
      errors++;
      $display("FAIL post_reset_frame got count %0d cmd=%0h arg=%h fe=%0d ov=%0d want 0/ffffffff",
               got_q.size(), cmd, cmd_arg0, n_ferr - f0, n_ovr - o0);
    end
  endtask

  task automatic test_random;
    int f0 = n_ferr, o0 = n_ovr, exp_ferr = 0;
    logic [7:0] b;
    logic [2:0] c;
    logic [31:0] a;
    int nargs;
    got_q.delete();
    exp_q.delete();
    for (int f = 0; f < 12; f++) begin
      case ($urandom_range(0, 2))
        0: begin
          c = 3'($urandom_range(0, 7));
          a = $urandom;
          send_frame(c, a);
          exp_q.push_back({c, a});
        end
        1: begin
          b = 8'($urandom);
          if (b[7:3] == HDR) b[7] = ~b[7];
          send_byte(b, 1'b1);
        end
        default: begin
          nargs = $urandom_range(0, 3);
          send_byte({HDR, 3'($urandom_range(0, 7))}, 1'b1);
          for (int i = 0; i < nargs; i++) send_byte(8'($urandom), 1'b1);
          tick(TO + 50);
          exp_ferr++;
        end
      endcase
    end
    tick(10);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_cmd[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (n_ferr - f0 != exp_ferr || n_ovr != o0) begin
      errors++;
      $display("FAIL random_pulses got fe=%0d ov=%0d want %0d 0", n_ferr - f0, n_ovr - o0, exp_ferr);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_backpressure;
    test_bad_header;
    test_timeout;
    test_stop_err;
    test_reset_mid_frame;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
